// File: rtl/cnt8_bcd_conv.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, one bit per clock).
// Define SEG7_EN to add a registered 7-segment decode with leading-zero blanking on SEG.
module cnt8_bcd_conv #(
    parameter bit AUTO_START = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  BIN,
    output logic        busy,
    output logic        done,
    output logic [11:0] BCD
`ifdef SEG7_EN
    ,
    output logic [20:0] SEG
`endif
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t      state;
    logic [7:0]  shift_reg;
    logic [7:0]  last_bin;
    logic [11:0] scratch;
    logic [2:0]  iter;
    logic [11:0] adj;
    logic [11:0] next_scratch;
    logic        launch;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 3; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        next_scratch = {adj[10:0], shift_reg[7]};
    end

    assign launch = start || (AUTO_START && (BIN != last_bin));

`ifdef SEG7_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    logic [20:0] seg_next;

    // Tens is blanked only when the hundreds digit is blank as well.
    always_comb begin
        seg_next = {seg7(next_scratch[11:8]), seg7(next_scratch[7:4]), seg7(next_scratch[3:0])};
        if (next_scratch[11:8] == 4'd0) begin
            seg_next[20:14] = 7'h00;
            if (next_scratch[7:4] == 4'd0) begin
                seg_next[13:7] = 7'h00;
            end
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            BCD       <= 12'h000;
            last_bin  <= 8'd0;
            shift_reg <= 8'd0;
            scratch   <= 12'h000;
            iter      <= 3'd0;
`ifdef SEG7_EN
            SEG       <= {7'h00, 7'h00, 7'h3F};
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        shift_reg <= BIN;
                        last_bin  <= BIN;
                        scratch   <= 12'h000;
                        iter      <= 3'd0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch   <= next_scratch;
                    shift_reg <= {shift_reg[6:0], 1'b0};
                    iter      <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        BCD   <= next_scratch;
`ifdef SEG7_EN
                        SEG   <= seg_next;
`endif
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnt8_bcd_conv.sv
// Self-checking bench for cnt8_bcd_conv: random and directed conversions against a
// decimal-arithmetic reference model; a second instance exercises AUTO_START=1.
module tb_cnt8_bcd_conv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start_a;
    logic [7:0]  bin;
    logic [7:0]  bin_a;
    logic        busy, done, busy_a, done_a;
    logic [11:0] bcd, bcd_a;
`ifdef SEG7_EN
    logic [20:0] seg, seg_a;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    cnt8_bcd_conv #(.AUTO_START(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .BIN(bin),
        .busy(busy), .done(done), .BCD(bcd)
`ifdef SEG7_EN
        , .SEG(seg)
`endif
    );

    cnt8_bcd_conv #(.AUTO_START(1'b1)) dut_auto (
        .clk(clk), .rst(rst), .start(start_a), .BIN(bin_a),
        .busy(busy_a), .done(done_a), .BCD(bcd_a)
`ifdef SEG7_EN
        , .SEG(seg_a)
`endif
    );

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [20:0] ref_seg(input int v);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        return {(h == 0) ? 7'h00 : SEG_TAB[h],
                (h == 0 && t == 0) ? 7'h00 : SEG_TAB[t],
                SEG_TAB[o]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launches one conversion and checks the full start/busy/done timeline; returns in the done cycle.
    task automatic run_conv(input int v, input string tag);
        bin   = 8'(v);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_launch: busy=%b done=%b, required busy=1 done=0", tag, busy, done);
        end
        for (int i = 1; i < 8; i++) begin
            step();
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy_cyc%0d: busy=%b done=%b, required busy=1 done=0", tag, i, busy, done);
            end
        end
        step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%b busy=%b, required done=1 busy=0", tag, done, busy);
        end
        checks++;
        if (bcd !== ref_bcd(v)) begin
            errors++;
            $display("FAIL %s_bcd: got %h, required %h (bin=%0d)", tag, bcd, ref_bcd(v), v);
        end
`ifdef SEG7_EN
        checks++;
        if (seg !== ref_seg(v)) begin
            errors++;
            $display("FAIL %s_seg: got %h, required %h (bin=%0d)", tag, seg, ref_seg(v), v);
        end
`endif
    endtask

    task automatic done_drops(input string tag);
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_width: done=%b, required 0", tag, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; start_a = 1'b0; bin = 8'd0; bin_a = 8'd0;
        step();
        step();
        checks++;
        if (bcd !== 12'h000 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: bcd=%h busy=%b done=%b, required 000/0/0", bcd, busy, done);
        end
`ifdef SEG7_EN
        checks++;
        if (seg !== {7'h00, 7'h00, 7'h3F}) begin
            errors++;
            $display("FAIL reset_seg: got %h, required %h", seg, {7'h00, 7'h00, 7'h3F});
        end
`endif
        rst = 1'b1;
        step();
    endtask

    task automatic test_max();
        run_conv(255, "max");
        done_drops("max");
    endtask

    task automatic test_blanking();
        run_conv(9, "blank9");
        done_drops("blank9");
        run_conv(100, "blank100");
        done_drops("blank100");
        run_conv(0, "zero");
        done_drops("zero");
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            run_conv(int'($urandom_range(0, 255)), "rand");
            step();
        end
    endtask

    task automatic test_back_to_back();
        run_conv(199, "b2b_first");
        run_conv(42, "b2b_second");
        done_drops("b2b_second");
    endtask

    task automatic test_start_while_busy();
        int ndone;
        logic [11:0] bcd_at_done;
        ndone = 0;
        bcd_at_done = 12'hFFF;
        bin = 8'd37; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        bin = 8'd200; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done === 1'b1) begin
                ndone++;
                bcd_at_done = bcd;
            end
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL busy_start_count: %0d done pulses, required 1", ndone);
        end
        checks++;
        if (bcd_at_done !== 12'h037) begin
            errors++;
            $display("FAIL busy_start_bcd: got %h, required 037", bcd_at_done);
        end
    endtask

    task automatic test_no_auto();
        int nbusy;
        nbusy = 0;
        for (int i = 0; i < 10; i++) begin
            bin = 8'(i * 23 + 5);
            step();
            if (busy !== 1'b0 || done !== 1'b0) nbusy++;
        end
        checks++;
        if (nbusy != 0) begin
            errors++;
            $display("FAIL no_auto: %0d cycles with busy/done, required 0", nbusy);
        end
    endtask

    task automatic test_reset_mid();
        int nact;
        nact = 0;
        run_conv(77, "pre_abort");
        step();
        bin = 8'd150; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b bcd=%h, required 0/0/000", busy, done, bcd);
        end
`ifdef SEG7_EN
        checks++;
        if (seg !== {7'h00, 7'h00, 7'h3F}) begin
            errors++;
            $display("FAIL abort_seg: got %h, required %h", seg, {7'h00, 7'h00, 7'h3F});
        end
`endif
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) nact++;
        end
        checks++;
        if (nact != 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d active cycles after abort, required 0", nact);
        end
    endtask

    task automatic test_auto_start();
        int nact;
        int waited;
        nact = 0;
        bin_a = 8'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (busy_a !== 1'b0 || done_a !== 1'b0) nact++;
        end
        checks++;
        if (nact != 0) begin
            errors++;
            $display("FAIL auto_zero: %0d active cycles with BIN=0, required 0", nact);
        end
        bin_a = 8'd128;
        step();
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL auto_launch: busy=%b, required 1", busy_a);
        end
        waited = 0;
        while (done_a !== 1'b1 && waited < 12) begin
            step();
            waited++;
        end
        checks++;
        if (done_a !== 1'b1 || waited != 8) begin
            errors++;
            $display("FAIL auto_done: done=%b after %0d cycles, required done=1 after 8", done_a, waited);
        end
        checks++;
        if (bcd_a !== ref_bcd(128)) begin
            errors++;
            $display("FAIL auto_bcd: got %h, required %h", bcd_a, ref_bcd(128));
        end
        nact = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done_a !== 1'b0 || busy_a !== 1'b0) nact++;
        end
        checks++;
        if (nact != 0) begin
            errors++;
            $display("FAIL auto_hold: %0d active cycles with BIN held, required 0", nact);
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_blanking();
        test_random();
        test_back_to_back();
        test_start_while_busy();
        test_no_auto();
        test_reset_mid();
        test_auto_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cnt8_bcd_conv.md
# cnt8_bcd_conv

Sequential binary-to-BCD converter that sits directly downstream of the 8-bit up counter and turns its 8-bit count into three BCD digits for the display stage. It uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock, behind a start/busy/done handshake. An optional 7-segment decode with leading-zero blanking can be compiled in.

## Interface

- AUTO_START, default 0: when 1, a conversion also launches whenever `BIN` differs from the last value latched for conversion.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- start  in  1  conversion request; sampled only in IDLE.
- BIN  in  8  binary value to convert, normally the counter's `OUT`.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when `BCD` has just been updated.
- BCD  out  12  {hundreds, tens, ones}, 4 bits each; registered; holds the last result.
- SEG  out  21  {hundreds, tens, ones} 7-segment codes, gfedcba, active-high; present only with `SEG7_EN`.

## Operation

- States:
  - IDLE: accepts work.
  - SHIFT: runs 8 iterations tracked by a 3-bit iteration counter.
- IDLE → SHIFT on `start`=1, or on (`AUTO_START`=1 and `BIN` != `last_bin`).
  - On that edge, latch `BIN` into an 8-bit shift register and into `last_bin`.
  - Clear the 12-bit scratch register and the iteration counter.
  - Set `busy`=1.
- SHIFT, once per cycle:
  - Add 3 to each scratch digit that is ≥5.
  - Then shift {scratch, shift_reg} left by 1 bit.
  - Increment the iteration counter.
- After the 8th iteration:
  - Load the corrected scratch value into `BCD`.
  - Pulse `done`=1 for one cycle.
  - Set `busy`=0 and return to IDLE.
- `start` while in SHIFT is ignored, not queued. `BIN` changes during SHIFT do not affect the running conversion.
- Arithmetic: the digit add is 4-bit with no carry out. The digit ≥5 check runs before the shift. The result is always a valid BCD value in 000..255.
- `last_bin` resets to 0, so with `AUTO_START`=1 a post-reset `BIN` of 0 triggers no conversion.

## Timing

- `start` sampled high at edge k:
  - `busy`=1 after edge k.
  - Shifts occur at edges k+1..k+8.
  - At edge k+8: `BCD` and `SEG` update, `done`=1, `busy`=0.
- Latency from the `start` edge to `done` is 8 cycles.
- `done` is high for exactly one cycle, the cycle after edge k+8.
- A `start` asserted in the cycle where `done`=1 is accepted, because the FSM is already in IDLE. Maximum throughput is one conversion per 9 cycles.
- `rst`=0 at any edge, including mid-SHIFT:
  - State becomes IDLE; `busy`=0, `done`=0, `BCD`=12'h000, `last_bin`=0.
  - `SEG` shows blank, blank, "0".
  - An aborted conversion never produces `done`.
- `rst` has priority over `start` and over auto-start on the same edge.

## Configuration

- `SEG7_EN` defined:
  - `SEG` port and a registered decoder are present, updated on the same edge as `BCD`.
  - Digit codes: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Leading-zero blanking: hundreds shows 7'h00 when 0; tens shows 7'h00 when hundreds and tens are both 0; ones is never blanked.
- `SEG7_EN` undefined: no `SEG` port and no decode logic. All other behaviour is identical.

## Test plan

- Reset check: hold `rst`=0 for 2 cycles → `BCD`=12'h000, `busy`=0, `done`=0, `SEG`={7'h00, 7'h00, 7'h3F}.
- Maximum value: `BIN`=8'd255 with a 1-cycle `start` → `busy` high for 8 cycles, `done` pulses 8 cycles after the start edge, `BCD`=12'h255.
- Blanking: `BIN`=8'd9 with `start` → `BCD`=12'h009, `SEG`={7'h00, 7'h00, 7'h6F}. Then `BIN`=8'd100 with `start` → `BCD`=12'h100, `SEG`={7'h06, 7'h3F, 7'h3F}.
- Start while busy: `start` with `BIN`=8'd37, then at the 3rd busy cycle `BIN`=8'd200 with `start` pulsed → a single `done`, `BCD`=12'h037, second request dropped.
- Reset mid-conversion: `rst`=0 during the 4th shift cycle → `busy`=0 next cycle, `BCD`=12'h000, no `done` for the aborted conversion.
- Auto-start (`AUTO_START`=1): `BIN` steps 0→128 with `start`=0 → one conversion, `BCD`=12'h128. Then hold `BIN` for 20 cycles → no further `done`.
